// File: rtl/csr_file_if.sv
// csr_file_if: bus between the pipeline and the machine-mode CSR file.
// Carries the execute-stage read port, the writeback/commit update port,
// trap/mret commit requests and the registered fetch redirect.
//   master : pipeline side (drives reads, commits, traps, mret)
//   slave  : csr_file side (returns read data, redirect and illegal pulse)
interface csr_file_if #(
  parameter int unsigned XLEN = 64
);
  logic [11:0]     csr_raddr;
  logic [XLEN-1:0] csr_rdata;
  logic            wb_valid;
  logic [1:0]      wb_op;
  logic [11:0]     wb_waddr;
  logic [XLEN-1:0] wb_src;
  logic            instret_inc;
  logic            trap_valid;
  logic [XLEN-1:0] trap_cause;
  logic [XLEN-1:0] trap_pc;
  logic            mret_valid;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            csr_illegal;

  modport master (
    output csr_raddr, wb_valid, wb_op, wb_waddr, wb_src, instret_inc,
           trap_valid, trap_cause, trap_pc, mret_valid,
    input  csr_rdata, redirect_valid, redirect_pc, csr_illegal
  );

  modport slave (
    input  csr_raddr, wb_valid, wb_op, wb_waddr, wb_src, instret_inc,
           trap_valid, trap_cause, trap_pc, mret_valid,
    output csr_rdata, redirect_valid, redirect_pc, csr_illegal
  );
endinterface

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR register file.
// Combinational read for execute, CSRRW/RS/RC + trap entry + mret applied at
// commit, mcycle/minstret counters, one-cycle registered redirect to fetch.
// Ports:
//   clk    : single clock, rising edge
//   reset  : synchronous, active-low
//   bus    : csr_file_if.slave (read port, commit port, trap/mret, redirect,
//            csr_illegal)
// Optional feature: define CSR_FWD_EN for a same-cycle writeback-to-read bypass.
module csr_file #(
  parameter int unsigned     XLEN        = 64,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0,
  parameter logic [XLEN-1:0] HART_ID     = '0
) (
  input  logic     clk,
  input  logic     reset,
  csr_file_if.slave bus
);

  localparam int unsigned AW = 12;

  localparam logic [AW-1:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [AW-1:0] ADDR_MTVEC    = 12'h305;
  localparam logic [AW-1:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [AW-1:0] ADDR_MEPC     = 12'h341;
  localparam logic [AW-1:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [AW-1:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [AW-1:0] ADDR_MINSTRET = 12'hB02;
  localparam logic [AW-1:0] ADDR_MHARTID  = 12'hF14;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  // mepc is kept 4-byte aligned in storage so it never needs read masking
  localparam logic [XLEN-1:0] EPC_MASK = ~XLEN'(3);

  typedef enum logic {ST_IDLE, ST_REDIR} state_e;

  state_e          state_q, state_d;
  logic            mie_q, mie_d;
  logic            mpie_q, mpie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mcycle_q, mcycle_d;
  logic [XLEN-1:0] minstret_q, minstret_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            illegal_q, illegal_d;

  logic [XLEN-1:0] mstatus_rd;
  logic [XLEN-1:0] rd_data;
  logic [XLEN-1:0] wr_old;
  logic [XLEN-1:0] wr_new;
  logic            wr_en;
  logic            wr_legal;

  // mstatus view: only MIE/MPIE are stored, MPP is hardwired to machine mode
  always_comb begin
    mstatus_rd        = '0;
    mstatus_rd[12:11] = 2'b11;
    mstatus_rd[7]     = mpie_q;
    mstatus_rd[3]     = mie_q;
  end

  // Architectural read view of one CSR address
  function automatic logic [XLEN-1:0] csr_view(input logic [AW-1:0] addr);
    logic [XLEN-1:0] r;
    r = '0;
    case (addr)
      ADDR_MSTATUS:  r = mstatus_rd;
      ADDR_MTVEC:    r = mtvec_q;
      ADDR_MSCRATCH: r = mscratch_q;
      ADDR_MEPC:     r = mepc_q;
      ADDR_MCAUSE:   r = mcause_q;
      ADDR_MCYCLE:   r = mcycle_q;
      ADDR_MINSTRET: r = minstret_q;
      ADDR_MHARTID:  r = HART_ID;
      default:       r = '0;
    endcase
    return r;
  endfunction

  assign rd_data = csr_view(bus.csr_raddr);
  assign wr_old  = csr_view(bus.wb_waddr);

  // Commit-side write value and qualification; RS/RC with zero source is a pure read
  always_comb begin
    wr_new = wr_old;
    case (bus.wb_op)
      OP_RW:   wr_new = bus.wb_src;
      OP_RS:   wr_new = wr_old | bus.wb_src;
      OP_RC:   wr_new = wr_old & ~bus.wb_src;
      default: wr_new = wr_old;
    endcase
  end

  assign wr_en = bus.wb_valid && (bus.wb_op != 2'b00)
                 && !bus.trap_valid && !bus.mret_valid
                 && ((bus.wb_op == OP_RW) || (bus.wb_src != '0));

  always_comb begin
    wr_legal = 1'b0;
    case (bus.wb_waddr)
      ADDR_MSTATUS, ADDR_MTVEC, ADDR_MSCRATCH, ADDR_MEPC,
      ADDR_MCAUSE, ADDR_MCYCLE, ADDR_MINSTRET: wr_legal = 1'b1;
      default:                                 wr_legal = 1'b0;
    endcase
  end

  // Next-state: trap > mret > CSR write; counters tick unless overwritten
  always_comb begin
    state_d       = ST_IDLE;
    mie_d         = mie_q;
    mpie_d        = mpie_q;
    mtvec_d       = mtvec_q;
    mscratch_d    = mscratch_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mcycle_d      = mcycle_q + XLEN'(1);
    minstret_d    = bus.instret_inc ? minstret_q + XLEN'(1) : minstret_q;
    redirect_pc_d = redirect_pc_q;
    illegal_d     = 1'b0;

    if (bus.trap_valid) begin
      mepc_d        = bus.trap_pc & EPC_MASK;
      mcause_d      = bus.trap_cause;
      mpie_d        = mie_q;
      mie_d         = 1'b0;
      state_d       = ST_REDIR;
      redirect_pc_d = {mtvec_q[XLEN-1:2], 2'b00};
    end else if (bus.mret_valid) begin
      mie_d         = mpie_q;
      mpie_d        = 1'b1;
      state_d       = ST_REDIR;
      redirect_pc_d = mepc_q;
    end else if (wr_en) begin
      if (!wr_legal) begin
        illegal_d = 1'b1;
      end else begin
        case (bus.wb_waddr)
          ADDR_MSTATUS: begin
            mie_d  = wr_new[3];
            mpie_d = wr_new[7];
          end
          ADDR_MTVEC:    mtvec_d    = wr_new;
          ADDR_MSCRATCH: mscratch_d = wr_new;
          ADDR_MEPC:     mepc_d     = wr_new & EPC_MASK;
          ADDR_MCAUSE:   mcause_d   = wr_new;
          ADDR_MCYCLE:   mcycle_d   = wr_new;
          ADDR_MINSTRET: minstret_d = wr_new;
          default: ;
        endcase
      end
    end
  end

  // State register; reset dominates every other input
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      mie_q         <= 1'b0;
      mpie_q        <= 1'b0;
      mtvec_q       <= MTVEC_RESET;
      mscratch_q    <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mcycle_q      <= '0;
      minstret_q    <= '0;
      redirect_pc_q <= '0;
      illegal_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      mie_q         <= mie_d;
      mpie_q        <= mpie_d;
      mtvec_q       <= mtvec_d;
      mscratch_q    <= mscratch_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mcycle_q      <= mcycle_d;
      minstret_q    <= minstret_d;
      redirect_pc_q <= redirect_pc_d;
      illegal_q     <= illegal_d;
    end
  end

  assign bus.redirect_valid = (state_q == ST_REDIR);
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.csr_illegal    = illegal_q;

`ifdef CSR_FWD_EN
  logic            fwd_hit;
  logic [XLEN-1:0] wr_view;

  // Forwarded value is shown exactly as it will read back after the commit edge
  always_comb begin
    wr_view = wr_new;
    case (bus.wb_waddr)
      ADDR_MSTATUS: begin
        wr_view        = '0;
        wr_view[12:11] = 2'b11;
        wr_view[7]     = wr_new[7];
        wr_view[3]     = wr_new[3];
      end
      ADDR_MEPC: wr_view = wr_new & EPC_MASK;
      default:   wr_view = wr_new;
    endcase
  end

  // Unwritable addresses never change, so their registered value is already correct
  assign fwd_hit = bus.wb_valid && (bus.wb_op != 2'b00) && wr_legal
                   && !bus.trap_valid && !bus.mret_valid
                   && (bus.wb_waddr == bus.csr_raddr);

  assign bus.csr_rdata = fwd_hit ? wr_view : rd_data;
`else
  assign bus.csr_rdata = rd_data;
`endif

endmodule
